// File: rtl/fp32_adder.sv
// fp32_adder
//   Registered IEEE-754 binary32 adder. This is the floating-point execution
//   unit of the mini-MIPS core and serves add.s and sub.s. For sub.s the core
//   flips bit 31 of the second operand before presenting it, so this block
//   only ever adds.
//   Denormal inputs are flushed to zero (DAZ), tiny results are flushed to
//   zero (FTZ), NaN results are canonical, and rounding is nearest-even.
//
// Ports
//   clk    in   1   rising-edge clock
//   reset  in   1   synchronous, active-high; clears out
//   inp1   in  32   operand A (sign[31], exp[30:23], frac[22:0])
//   inp2   in  32   operand B, same format
//   out    out 32   inp1 + inp2, registered one cycle after the inputs
module fp32_adder (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inp1,
  input  logic [31:0] inp2,
  output logic [31:0] out
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Field extraction and operand classification
  logic       sa, sb;
  logic [7:0] ea, eb;
  logic [22:0] fa, fb;
  logic       a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign sa = inp1[31];
  assign sb = inp2[31];
  assign ea = inp1[30:23];
  assign eb = inp2[30:23];
  assign fa = inp1[22:0];
  assign fb = inp2[22:0];

  assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
  assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
  // Exponent 0 covers both true zero and denormals (DAZ).
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);

  // Normal datapath signals
  logic        a_is_big;
  logic        s_big, s_small;
  logic [7:0]  e_big, e_small, e_diff;
  logic [26:0] big_ext, small_ext, small_sh, lost_mask;
  logic [27:0] sum;
  logic [26:0] mag, norm;
  logic [4:0]  lzc;
  logic        add_carry;
  logic        cancel;
  logic        round_up;
  logic [24:0] mant_rnd;
  logic [22:0] frac_fin;
  logic [9:0]  exp_norm, exp_fin;
  logic        res_sign;
  logic [31:0] normal_res;
  logic [31:0] result;

  // NOTE: every signal written in a combinational block gets a default at
  // the top of the block, so no path can leave it unassigned and infer a latch.
  always_comb begin
    a_is_big   = ({ea, fa} >= {eb, fb});
    s_big      = a_is_big ? sa : sb;
    s_small    = a_is_big ? sb : sa;
    e_big      = a_is_big ? ea : eb;
    e_small    = a_is_big ? eb : ea;
    // Significand with hidden 1, followed by guard, round and sticky.
    big_ext    = a_is_big ? {1'b1, fa, 3'b000} : {1'b1, fb, 3'b000};
    small_ext  = a_is_big ? {1'b1, fb, 3'b000} : {1'b1, fa, 3'b000};
    e_diff     = e_big - e_small;

    // Alignment: bits shifted past the sticky position are ORed into sticky.
    // At a distance of 27 or more nothing but sticky survives.
    lost_mask  = '0;
    small_sh   = '0;
    if (e_diff >= 8'd27) begin
      small_sh = 27'd1;
    end else begin
      lost_mask = (27'd1 << e_diff) - 27'd1;
      small_sh  = (small_ext >> e_diff) | {26'd0, |(small_ext & lost_mask)};
    end

    sum       = '0;
    mag       = '0;
    lzc       = '0;
    add_carry = 1'b0;
    cancel    = 1'b0;
    norm      = '0;

    if (s_big == s_small) begin
      sum       = {1'b0, big_ext} + {1'b0, small_sh};
      add_carry = sum[27];
      // Carry-out: shift right one place, keeping the dropped bit in sticky.
      norm      = add_carry ? {sum[27:2], sum[1] | sum[0]} : sum[26:0];
    end else begin
      // big >= small in magnitude, so this never goes negative.
      mag    = big_ext - small_sh;
      cancel = (mag == 27'd0);
      // Leading-zero count: the highest set bit wins as the loop runs upward.
      for (int i = 0; i < 27; i++) begin
        if (mag[i]) lzc = 5'(26 - i);
      end
      norm = mag << lzc;
    end

    // Round to nearest, ties to even: guard set and (round|sticky|lsb).
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_rnd = {1'b0, norm[26:3]} + {24'd0, round_up};
    // A rounding carry means the significand became exactly 2.0: its fraction
    // bits are all zero after the renormalizing shift.
    frac_fin = mant_rnd[24] ? mant_rnd[23:1] : mant_rnd[22:0];

    // Exponent kept in 10-bit two's complement so over/underflow cannot wrap.
    exp_norm = {2'b00, e_big} + {9'd0, add_carry} - {5'd0, lzc};
    exp_fin  = exp_norm + {9'd0, mant_rnd[24]};

    res_sign = s_big;
    if (cancel) begin
      normal_res = 32'h0000_0000;
    end else if ($signed(exp_fin) >= 10'sd255) begin
      normal_res = {res_sign, 8'hFF, 23'd0};
    end else if ($signed(exp_fin) <= 10'sd0) begin
      normal_res = {res_sign, 31'd0};
    end else begin
      normal_res = {res_sign, exp_fin[7:0], frac_fin};
    end

    // Special cases in priority order, normal datapath last.
    if (a_nan || b_nan) begin
      result = QNAN;
    end else if (a_inf && b_inf && (sa != sb)) begin
      result = QNAN;
    end else if (a_inf) begin
      result = {sa, 8'hFF, 23'd0};
    end else if (b_inf) begin
      result = {sb, 8'hFF, 23'd0};
    end else if (a_zero && b_zero) begin
      result = {sa & sb, 31'd0};
    end else if (a_zero) begin
      result = inp2;
    end else if (b_zero) begin
      result = inp1;
    end else begin
      result = normal_res;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      out <= 32'h0000_0000;
    end else begin
      out <= result;
    end
  end

endmodule

// File: tb/tb_fp32_adder.sv
// tb_fp32_adder
//   Self-checking bench for fp32_adder. Inputs are driven on the falling edge;
//   the expected result is pushed onto a scoreboard queue at the same time and
//   popped/compared on the next falling edge, after the rising edge that
//   registered it. Back-to-back calls give one operand pair per cycle.
module tb_fp32_adder;

  logic        clk;
  logic        reset;
  logic [31:0] inp1;
  logic [31:0] inp2;
  logic [31:0] out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] expected;
    string       tag;
  } sb_entry_t;

  sb_entry_t sb_q[$];

  fp32_adder dut (
    .clk   (clk),
    .reset (reset),
    .inp1  (inp1),
    .inp2  (inp2),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h", tag, actual, expected);
    end
  endtask

  // Compare the oldest pending result, if any, against the current output.
  task automatic retire();
    sb_entry_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, out, e.expected);
    end
  endtask

  // One cycle: retire the previous result, then present new inputs.
  task automatic step(input logic rst, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] expected, input string tag);
    sb_entry_t e;
    @(negedge clk);
    retire();
    reset = rst;
    inp1  = a;
    inp2  = b;
    e.expected = expected;
    e.tag      = tag;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    while (sb_q.size() > 0) begin
      @(negedge clk);
      retire();
    end
  endtask

  // Watchdog: the run is a fixed sequence, so this only fires on a bench hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    inp1  = 32'h3F80_0000;
    inp2  = 32'h4000_0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", out, 32'h0000_0000);

    // Reset held, then released with the same operands.
    step(1'b1, 32'h3F80_0000, 32'h4000_0000, 32'h0000_0000, "reset_held");
    step(1'b0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, "first_after_reset");

    // Cancellation and subtraction
    step(1'b0, 32'h3FC0_0000, 32'hBFC0_0000, 32'h0000_0000, "exact_cancel");
    step(1'b0, 32'h40A0_0000, 32'hC040_0000, 32'h4000_0000, "sub_5_minus_3");
    step(1'b0, 32'h3F80_0000, 32'hBF7F_FFFF, 32'h3380_0000, "lzc_normalize");
    step(1'b0, 32'hBF80_0000, 32'h3F80_0000, 32'h0000_0000, "neg_cancel_pos_zero");

    // Rounding
    step(1'b0, 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, "tie_even");
    step(1'b0, 32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002, "tie_odd");
    step(1'b0, 32'h3F80_0000, 32'h0000_0001, 32'h3F80_0000, "daz_denormal");
    step(1'b0, 32'h4E80_0000, 32'h3F80_0000, 32'h4E80_0000, "far_shift_sticky");
    step(1'b0, 32'h4E80_0000, 32'hBF80_0000, 32'h4E80_0000, "far_sub_round_carry");

    // Overflow, underflow and specials
    step(1'b0, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, "overflow_add");
    step(1'b0, 32'h7F7F_FFFF, 32'h7300_0000, 32'h7F80_0000, "overflow_round");
    step(1'b0, 32'h0080_0001, 32'h8080_0000, 32'h0000_0000, "underflow_ftz");
    step(1'b0, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, "inf_minus_inf");
    step(1'b0, 32'h7FC1_2345, 32'h3F80_0000, 32'h7FC0_0000, "nan_in");
    step(1'b0, 32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, "neg_inf");
    step(1'b0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, "neg_zero_sum");
    step(1'b0, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, "mixed_zero_sum");
    step(1'b0, 32'h8000_0001, 32'h8000_0001, 32'h8000_0000, "daz_both_neg");
    step(1'b0, 32'h0000_0000, 32'hC0A0_0000, 32'hC0A0_0000, "zero_passthrough");

    // Back-to-back pipelining
    step(1'b0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, "pipe_1p1");
    step(1'b0, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, "pipe_2p2");
    step(1'b0, 32'h4040_0000, 32'h4040_0000, 32'h40C0_0000, "pipe_3p3");
    step(1'b0, 32'h4080_0000, 32'h4080_0000, 32'h4100_0000, "pipe_4p4");

    // Reset asserted mid-stream, then recovery
    step(1'b1, 32'h4080_0000, 32'h4080_0000, 32'h0000_0000, "reset_mid_stream");
    step(1'b0, 32'h40A0_0000, 32'h40A0_0000, 32'h4120_0000, "after_mid_reset");

    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp32_adder.md
Name: fp32_adder

Overview:
- Registered IEEE-754 single-precision adder; the floating-point execution unit of the mini-MIPS core, serving add.s and sub.s.
- The core performs sub.s by XOR-ing bit 31 of the second operand before presenting it, so the block only adds.
- Inputs are sampled every clock, and the result appears registered one cycle later.

Parameters:
- none

Ports:
- clk  input  1  rising-edge clock, the only clock in the block
- reset  input  1  synchronous, active-high; clears the output register
- inp1  input  32  operand A, IEEE-754 binary32 (sign[31], exp[30:23], frac[22:0])
- inp2  input  32  operand B, same format (already sign-flipped by the core for sub.s)
- out  output  32  registered result of inp1 + inp2, binary32

Behaviour:
- One clock domain, clk.
- Reset is synchronous and active-high.
  - When reset is high at a rising edge of clk, out becomes 32'h00000000, regardless of the inputs.
  - Reset of out: 32'h00000000.
- Latency:
  - The datapath is combinational from inp1/inp2 to the output register D input.
  - out updates every rising clk edge on which reset is low, so the result of inputs applied in cycle N is visible after edge N+1.
  - Throughput is one result per cycle. There is no handshake and no stall.
- Operand classification:
  - Exponent 0xFF with frac≠0 is NaN.
  - Exponent 0xFF with frac=0 is ±Inf.
  - Exponent 0 is zero. Denormal inputs are treated as zero with their sign kept (DAZ).
  - Anything else is normal, with hidden bit 1.
- Special results, in priority order:
  - Either operand NaN → 32'h7FC00000 (canonical quiet NaN).
  - +Inf + -Inf → 32'h7FC00000.
  - Any other Inf present → that Inf.
  - Both operands zero → +0, except (-0)+(-0) = -0.
  - One operand zero → the other operand, unchanged. A denormal input that was flushed to zero counts as zero here.
- Normal datapath:
  - Swap the operands so the operand with the larger magnitude (exponent then fraction) is first.
  - Extend each 24-bit significand with guard, round and sticky bits.
  - Right-shift the smaller operand by the exponent difference. Any bits shifted out OR into sticky. A difference of 27 or more collapses the smaller operand to sticky only.
  - Same signs: add. A carry-out shifts right by 1 (folding into sticky) and increments the exponent.
  - Different signs: subtract smaller from larger. Normalize with a leading-zero count and left shift, decrementing the exponent.
  - Exact cancellation gives +0.
  - Result sign is the sign of the larger-magnitude operand.
- Rounding:
  - Round-to-nearest-even, using guard/round/sticky.
  - A rounding carry out of the mantissa renormalizes and increments the exponent.
- Overflow: a final exponent of 255 or more gives signed infinity (exp 0xFF, frac 0).
- Underflow: a final biased exponent of 0 or less gives signed zero (FTZ). Denormal results are never produced.
- Exponent arithmetic uses at least 10-bit signed intermediates so that underflow and overflow are detected without wrap-around.
- Pure function of the inputs; no state other than the out register.
- Reset asserted mid-stream: the next edge shows 0.
- After reset deasserts, the first valid result appears one edge after the inputs are applied.

Test Plan:
- Reset:
  - Hold reset=1 with inp1=32'h3F800000, inp2=32'h40000000 → out=32'h00000000 after the edge.
  - Deassert reset → the next edge gives out=32'h40400000 (1+2=3).
- Cancellation and subtraction:
  - 32'h3FC00000 + 32'hBFC00000 → 32'h00000000.
  - sub.s form 32'h40A00000 + 32'hC0400000 (5 + -3) → 32'h40000000.
  - 32'h3F800000 + 32'hBF7FFFFF → 32'h33800000, exercising the leading-zero normalize.
- Rounding:
  - 32'h3F800000 + 32'h33800000 (tie, even) → 32'h3F800000.
  - 32'h3F800001 + 32'h33800000 (tie, odd) → 32'h3F800002.
  - 32'h3F800000 + 32'h00000001 (denormal, DAZ) → 32'h3F800000.
- Overflow and specials:
  - 32'h7F7FFFFF + 32'h7F7FFFFF → 32'h7F800000.
  - 32'h7F800000 + 32'hFF800000 → 32'h7FC00000.
  - 32'h7FC12345 + 32'h3F800000 → 32'h7FC00000.
  - 32'hFF800000 + 32'h3F800000 → 32'hFF800000.
  - 32'h80000000 + 32'h80000000 → 32'h80000000.
- Pipelining: apply a new operand pair every cycle for 4 cycles (for example 1+1, 2+2, 3+3, 4+4) → outputs 32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000 on consecutive edges, each one cycle late.
